// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register and a 1-entry skid buffer.
// Issues reads to a 1-cycle-latency synchronous instruction memory; supports redirect and halt.
module fetch_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_imem_ren,
  output logic [31:0] o_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_inst,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_pc_plus4,
  output logic        o_halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic        skid_v;
  logic [31:0] skid_inst, skid_pc;
  logic        if_valid_q;
  logic [31:0] if_inst_q, if_pc_q, if_pc_plus4_q;

  logic [31:0] redirect_target;
  logic        running, take_redirect, take_halt, issue_blocked, issue;
  logic        unused_redirect_bits;

  assign redirect_target      = {i_redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = &{1'b0, i_redirect_pc[1:0]};
  assign running              = (state_q == RUN);
  assign take_redirect        = running & i_redirect;
  assign take_halt            = running & i_halt & ~i_stall & ~i_redirect;
  // A held IF/ID with data already in flight or parked has nowhere to put another response.
  assign issue_blocked        = i_stall & (inflight_q | skid_v);

  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    o_imem_raddr = pc_q;
    if (!i_rst && running) begin
      if (take_redirect) begin
        issue        = 1'b1;
        o_imem_raddr = redirect_target;
      end else if (take_halt) begin
        state_d = HALTED;
      end else begin
        issue = ~issue_blocked;
      end
    end
  end

  assign o_imem_ren = issue;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q          <= RESET_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      skid_v        <= 1'b0;
      skid_inst     <= NOP_INST;
      skid_pc       <= 32'h0;
      if_valid_q    <= 1'b0;
      if_inst_q     <= NOP_INST;
      if_pc_q       <= 32'h0;
      if_pc_plus4_q <= 32'h4;
    end else if (!running) begin
      inflight_q <= 1'b0;
      skid_v     <= 1'b0;
      if_valid_q <= 1'b0;
      if_inst_q  <= NOP_INST;
    end else if (take_redirect) begin
      pc_q          <= redirect_target + 32'd4;
      inflight_q    <= 1'b1;
      inflight_pc_q <= redirect_target;
      skid_v        <= 1'b0;
      if_valid_q    <= 1'b0;
      if_inst_q     <= NOP_INST;
    end else if (take_halt) begin
      inflight_q <= 1'b0;
      skid_v     <= 1'b0;
      if_valid_q <= 1'b0;
      if_inst_q  <= NOP_INST;
    end else begin
      if (issue) begin
        pc_q          <= pc_q + 32'd4;
        inflight_q    <= 1'b1;
        inflight_pc_q <= pc_q;
      end else begin
        inflight_q <= 1'b0;
      end
      if (i_stall) begin
        if (inflight_q) begin
          skid_v    <= 1'b1;
          skid_inst <= i_imem_rdata;
          skid_pc   <= inflight_pc_q;
        end
      end else if (skid_v) begin
        skid_v        <= 1'b0;
        if_valid_q    <= 1'b1;
        if_inst_q     <= skid_inst;
        if_pc_q       <= skid_pc;
        if_pc_plus4_q <= skid_pc + 32'd4;
      end else if (inflight_q) begin
        if_valid_q    <= 1'b1;
        if_inst_q     <= i_imem_rdata;
        if_pc_q       <= inflight_pc_q;
        if_pc_plus4_q <= inflight_pc_q + 32'd4;
      end else begin
        if_valid_q <= 1'b0;
        if_inst_q  <= NOP_INST;
      end
    end
  end

  assign o_if_valid    = if_valid_q;
  assign o_if_inst     = if_inst_q;
  assign o_if_pc       = if_pc_q;
  assign o_if_pc_plus4 = if_pc_plus4_q;
  assign o_halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized stream check
// against an in-order instruction stream model.
module tb_fetch_stage;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, halt;
  logic [31:0] redirect_pc;
  logic        imem_ren;
  logic [31:0] imem_raddr, imem_rdata;
  logic        if_valid, halted;
  logic [31:0] if_inst, if_pc, if_pc_plus4;

  int errors = 0;
  int checks = 0;

  fetch_stage dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .i_halt(halt), .o_imem_ren(imem_ren),
    .o_imem_raddr(imem_raddr), .i_imem_rdata(imem_rdata), .o_if_valid(if_valid),
    .o_if_inst(if_inst), .o_if_pc(if_pc), .o_if_pc_plus4(if_pc_plus4), .o_halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data for a request appears in the following cycle.
  always @(posedge clk) imem_rdata <= imem_ren ? (imem_raddr ^ KEY) : 32'hDEAD_BEEF;

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic h, input logic [31:0] t);
    stall = s; redirect = r; halt = h; redirect_pc = t;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    adv(); adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    adv(); adv();
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", if_valid); end
    checks++; if (if_inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", if_inst, NOP); end
    checks++; if ({if_pc, if_pc_plus4} !== {32'h0, 32'h4}) begin errors++; $display("FAIL reset_pc: got %h/%h want 0/4", if_pc, if_pc_plus4); end
    checks++; if ({halted, imem_ren} !== 2'b00) begin errors++; $display("FAIL reset_halt_ren: got %b want 00", {halted, imem_ren}); end
  endtask

  task automatic test_stream();
    logic [31:0] p;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if ({imem_ren, imem_raddr} !== {1'b1, 32'(4 * i)}) begin errors++; $display("FAIL stream_req%0d: got %b/%h want 1/%h", i, imem_ren, imem_raddr, 4 * i); end
      if (i >= 2) begin
        p = 32'(4 * (i - 2));
        checks++; if ({if_valid, if_pc, if_inst, if_pc_plus4} !== {1'b1, p, p ^ KEY, p + 32'd4}) begin
          errors++; $display("FAIL stream_if%0d: got %b %h %h %h want pc %h", i, if_valid, if_pc, if_inst, if_pc_plus4, p); end
      end else begin
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_bubble%0d: got %0b want 0", i, if_valid); end
      end
      adv();
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (4) adv();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({if_valid, if_pc} !== {1'b1, 32'h8}) begin errors++; $display("FAIL stall_hold%0d: got %b/%h want 1/8", k, if_valid, if_pc); end
      checks++; if (imem_ren !== 1'b0) begin errors++; $display("FAIL stall_ren%0d: got %0b want 0", k, imem_ren); end
      adv();
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if ({imem_ren, imem_raddr} !== {1'b1, 32'h10}) begin errors++; $display("FAIL stall_release_req: got %b/%h want 1/10", imem_ren, imem_raddr); end
    adv(); @(negedge clk);
    checks++; if ({if_valid, if_pc, if_inst} !== {1'b1, 32'hC, 32'hC ^ KEY}) begin errors++; $display("FAIL stall_skid_out: got %b/%h/%h want 1/c", if_valid, if_pc, if_inst); end
    adv(); @(negedge clk);
    checks++; if ({if_valid, if_pc} !== {1'b1, 32'h10}) begin errors++; $display("FAIL stall_next: got %b/%h want 1/10", if_valid, if_pc); end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (4) adv();
    drive(1'b1, 1'b1, 1'b0, 32'h100);
    @(negedge clk);
    checks++; if ({imem_ren, imem_raddr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL redir_req: got %b/%h want 1/100", imem_ren, imem_raddr); end
    adv(); drive(1'b0, 1'b0, 1'b0, 32'h0); @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble: got %0b want 0", if_valid); end
    checks++; if (imem_raddr !== 32'h104) begin errors++; $display("FAIL redir_next_addr: got %h want 104", imem_raddr); end
    adv(); @(negedge clk);
    checks++; if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h100, 32'h100 ^ KEY}) begin errors++; $display("FAIL redir_tgt: got %b/%h/%h want 1/100", if_valid, if_pc, if_inst); end
    adv(); @(negedge clk);
    checks++; if ({if_valid, if_pc} !== {1'b1, 32'h104}) begin errors++; $display("FAIL redir_tgt4: got %b/%h want 1/104", if_valid, if_pc); end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (4) adv();
    halt = 1'b1;
    @(negedge clk);
    checks++; if (imem_ren !== 1'b0) begin errors++; $display("FAIL halt_cycle_ren: got %0b want 0", imem_ren); end
    adv();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, k == 3, 1'b0, 32'h200);
      @(negedge clk);
      checks++; if ({halted, if_valid, imem_ren} !== 3'b100) begin errors++; $display("FAIL halted%0d: got %b want 100", k, {halted, if_valid, imem_ren}); end
      adv();
    end
    // Halt and redirect together: redirect wins.
    do_reset();
    repeat (4) adv();
    drive(1'b0, 1'b1, 1'b1, 32'h40);
    @(negedge clk);
    checks++; if ({imem_ren, imem_raddr} !== {1'b1, 32'h40}) begin errors++; $display("FAIL halt_redir_req: got %b/%h want 1/40", imem_ren, imem_raddr); end
    adv(); drive(1'b0, 1'b0, 1'b0, 32'h0); @(negedge clk);
    checks++; if ({halted, if_valid} !== 2'b00) begin errors++; $display("FAIL halt_redir_state: got %b want 00", {halted, if_valid}); end
    adv(); @(negedge clk);
    checks++; if ({halted, if_valid, if_pc} !== {2'b01, 32'h40}) begin errors++; $display("FAIL halt_redir_tgt: got %b/%h want 01/40", {halted, if_valid}, if_pc); end
    // Halt under stall is deferred until the stall drops.
    do_reset();
    repeat (4) adv();
    drive(1'b1, 1'b0, 1'b1, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if ({halted, if_valid, if_pc} !== {2'b01, 32'h8}) begin errors++; $display("FAIL halt_stall%0d: got %b/%h want 01/8", k, {halted, if_valid}, if_pc); end
      adv();
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if ({halted, imem_ren} !== 2'b00) begin errors++; $display("FAIL halt_release: got %b want 00", {halted, imem_ren}); end
    adv(); halt = 1'b0; @(negedge clk);
    checks++; if ({halted, if_valid} !== 2'b10) begin errors++; $display("FAIL halt_after_stall: got %b want 10", {halted, if_valid}); end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (3) adv();
    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    @(negedge clk);
    checks++; if ({imem_ren, imem_raddr} !== {1'b1, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap_req: got %b/%h want 1/fffffffc", imem_ren, imem_raddr); end
    adv(); drive(1'b0, 1'b0, 1'b0, 32'h0); @(negedge clk);
    checks++; if ({if_valid, imem_raddr} !== {1'b0, 32'h0}) begin errors++; $display("FAIL wrap_next: got %b/%h want 0/0", if_valid, imem_raddr); end
    adv(); @(negedge clk);
    checks++; if ({if_valid, if_pc, if_inst, if_pc_plus4} !== {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC ^ KEY, 32'h0}) begin
      errors++; $display("FAIL wrap_top: got %b %h %h %h want 1 fffffffc - 0", if_valid, if_pc, if_inst, if_pc_plus4); end
    adv(); @(negedge clk);
    checks++; if ({if_valid, if_pc, if_pc_plus4} !== {1'b1, 32'h0, 32'h4}) begin errors++; $display("FAIL wrap_zero: got %b %h %h want 1 0 4", if_valid, if_pc, if_pc_plus4); end
    adv(); drive(1'b0, 1'b1, 1'b0, 32'h103); @(negedge clk);
    checks++; if ({imem_ren, imem_raddr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL unaligned_req: got %b/%h want 1/100", imem_ren, imem_raddr); end
    adv(); drive(1'b0, 1'b0, 1'b0, 32'h0); adv(); @(negedge clk);
    checks++; if ({if_valid, if_pc} !== {1'b1, 32'h100}) begin errors++; $display("FAIL unaligned_pc: got %b/%h want 1/100", if_valid, if_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (4) adv();
    stall = 1'b1;
    adv(); adv();
    rst = 1'b1;
    adv();
    rst = 1'b0; stall = 1'b0;
    @(negedge clk);
    checks++; if ({if_valid, if_inst, if_pc, if_pc_plus4, halted} !== {1'b0, NOP, 32'h0, 32'h4, 1'b0}) begin
      errors++; $display("FAIL rstmid_values: got %b %h %h %h %b", if_valid, if_inst, if_pc, if_pc_plus4, halted); end
    checks++; if ({imem_ren, imem_raddr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rstmid_req: got %b/%h want 1/0", imem_ren, imem_raddr); end
    adv(); adv(); @(negedge clk);
    checks++; if ({if_valid, if_pc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rstmid_first: got %b/%h want 1/0", if_valid, if_pc); end
    adv(); @(negedge clk);
    checks++; if ({if_valid, if_pc} !== {1'b1, 32'h4}) begin errors++; $display("FAIL rstmid_second: got %b/%h want 1/4", if_valid, if_pc); end
    // Reset out of HALTED.
    adv(); halt = 1'b1; adv(); halt = 1'b0; adv();
    @(negedge clk);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL rsthalt_pre: got %0b want 1", halted); end
    rst = 1'b1;
    adv();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({halted, if_valid, imem_ren, imem_raddr} !== {3'b001, 32'h0}) begin errors++; $display("FAIL rsthalt_exit: got %b/%h want 001/0", {halted, if_valid, imem_ren}, imem_raddr); end
    adv(); adv(); @(negedge clk);
    checks++; if ({if_valid, if_pc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rsthalt_first: got %b/%h want 1/0", if_valid, if_pc); end
  endtask

  // Decode sees one in-order stream: each consumed instruction is the previous +4, restarting at
  // every redirect target; no drops or duplicates regardless of stall pattern.
  task automatic test_random();
    logic [31:0] exp_pc, tgt;
    logic        s, r;
    int          consumed;
    do_reset();
    exp_pc = 32'h0;
    consumed = 0;
    for (int n = 0; n < 400; n++) begin
      s = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 9) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive(s, r, 1'b0, tgt);
      @(negedge clk);
      if (if_valid) begin
        checks++; if ({if_pc, if_inst, if_pc_plus4} !== {exp_pc, exp_pc ^ KEY, exp_pc + 32'd4}) begin
          errors++; $display("FAIL rand_stream%0d: got %h %h %h want pc %h", n, if_pc, if_inst, if_pc_plus4, exp_pc); end
      end
      if (r) begin
        checks++; if ({imem_ren, imem_raddr} !== {1'b1, tgt[31:2], 2'b00}) begin errors++; $display("FAIL rand_redir%0d: got %b/%h want 1/%h", n, imem_ren, imem_raddr, {tgt[31:2], 2'b00}); end
        exp_pc = {tgt[31:2], 2'b00};
      end else begin
        if (!s) begin
          checks++; if (imem_ren !== 1'b1) begin errors++; $display("FAIL rand_ren%0d: got %0b want 1", n, imem_ren); end
        end
        if (if_valid && !s) begin
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
      end
      adv();
    end
    checks++; if (consumed < 60) begin errors++; $display("FAIL rand_progress: got %0d want >= 60", consumed); end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
